pipe_hazard_scoreboard: RTL and testbench
=========================================

// Module: pipe_hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding unit for the valid/allowin pipelined CPU.
//  Sits beside ID and keeps a shadow copy of the STAGES post-ID stages: valid, we, dest, is_load.
//  Stages are EXE, MEM, WB by default. Tags advance under the same allowin/ready_go handshake as the datapath.
//  From these tags it produces the ID stall and the forwarded rs/rt operand values.
//  Generalises the fixed EXE-only load-use check to any depth, load latency and flush.
// PARAMETERS
//  STAGES      3   post-ID stages tracked; index 0 = EXE, STAGES-1 = WB
//  AW          5   register-number width
//  DW          32  data width
//  LOAD_STAGE  1   first stage index whose st_result holds load data (1 = MEM)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  flush          in   1          kill all in-flight tags (exception/redirect)
//  id_valid       in   1          ID holds a valid instruction
//  id_rs, id_rt   in   AW         ID source register numbers
//  id_use_rs      in   1          ID really reads rs
//  id_use_rt      in   1          ID really reads rt
//  id_we          in   1          ID instruction writes GPR
//  id_dest        in   AW         ID destination register
//  id_is_load     in   1          ID instruction is a load
//  id_to_s0_valid in   1          ds_valid && ds_ready_go
//  st_allowin     in   STAGES     per-stage allowin from datapath
//  st_ready_go    in   STAGES     per-stage ready_go from datapath
//  st_result      in   STAGES*DW  per-stage result; stage i at [i*DW +: DW]
//  rf_rdata1      in   DW         regfile read port for rs
//  rf_rdata2      in   DW         regfile read port for rt
//  stall          out  1          ID must not go (drives !ds_ready_go)
//  rs_value       out  DW         forwarded rs operand
//  rt_value       out  DW         forwarded rt operand
//  st_valid       out  STAGES     shadow valid bits (debug/verification)
// BEHAVIOUR
//  - Tag regs per stage i: v[i], we[i], dest[i], ld[i]. One clock (clk); reset synchronous, active-high.
//  - Reset: all v[i] <= 0 on the reset edge. We/dest/ld are don't-care.
//    After that edge: st_valid=0, stall=0, rs_value=rf_rdata1, rt_value=rf_rdata2.
//  - Advance, per stage, if st_allowin[i]:
//    - stage 0: v[0] <= id_to_s0_valid; fields loaded from id_*.
//    - stage i>0: v[i] <= v[i-1] && st_ready_go[i-1]; fields copied from i-1.
//    - !st_allowin[i]: hold.
//  - Last stage retires implicitly when its allowin refills or drains it.
//  - flush: all v[i] <= 0 next edge; overrides simultaneous advance/issue.
//    Reset overrides flush. Reset asserted mid-stream discards everything.
//  - Match: m_rs[i] = v[i] && we[i] && dest[i]!=0 && dest[i]==id_rs && id_use_rs (rt likewise).
//    Register 0 never matches.
//  - Priority: youngest match (lowest i) owns the operand; older matches are ignored.
//  - Readiness: stage i data ok = !ld[i] || i >= LOAD_STAGE.
//  - stall = id_valid && (owner of rs or rt exists && its data is not ok) [with forwarding].
//  - stall, rs_value, rt_value are combinational from tags + inputs: 0-cycle latency, no extra register.
//  - A stalled ID keeps id_to_s0_valid=0, so stage 0 receives a bubble when it allows in.
// CONFIGURATION
//  PIPE_FWD_EN defined:
//    - rs_value/rt_value = st_result of the owning stage, else RF data.
//    - stall only for not-ok data (load-use).
//  PIPE_FWD_EN undefined:
//    - no forwarding; rs_value=rf_rdata1, rt_value=rf_rdata2 always.
//    - stall = id_valid && any m_rs[i] or m_rt[i] over all stages, including WB.
//    - st_result is ignored.
// TESTING
//  1 reset held 2 cycles mid-stream with 3 valid tags -> st_valid=3'b000, stall=0 after the edge.
//  2 FWD: addu $3 in EXE (st_result[0]=32'h11), ID addu rs=$3 -> stall=0, rs_value=32'h11.
//  3 FWD: lw $5 in EXE, ID uses rt=$5 -> stall=1 for 1 cycle.
//    Then lw in MEM, st_result[1]=32'hCAFE -> stall=0, rt_value=32'hCAFE.
//  4 $7 written in EXE (32'hA) and MEM (32'hB) -> rs_value=32'hA. Dest $0 in EXE -> rf_rdata1 passes.
//  5 flush with id_to_s0_valid=1 and all st_allowin=1 -> st_valid=0 next cycle.
//  6 no FWD: addu $4 in WB, ID reads $4 -> stall=1 until WB drains.
//    id_use_rt=0 with rt=$4 -> stall=0.

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
//   Hazard / forwarding unit that sits beside ID in a valid/allowin pipeline.
//   It keeps a shadow tag (valid, we, dest, is_load) for each of the STAGES
//   post-ID stages. Index 0 is EXE and index STAGES-1 is WB. The tags advance
//   under the same allowin/ready_go handshake as the datapath. From the tags
//   the unit derives the ID stall and the rs/rt operand values.
//
//   Build option: define PIPE_FWD_EN to enable operand forwarding from
//   st_result. With forwarding, ID stalls only on load-use. Without it, ID
//   stalls on any in-flight writer of a source register, and the operands
//   always come straight from the register file.
module pipe_hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int LOAD_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rs,
  input  logic [AW-1:0]        id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_we,
  input  logic [AW-1:0]        id_dest,
  input  logic                 id_is_load,
  input  logic                 id_to_s0_valid,
  input  logic [STAGES-1:0]    st_allowin,
  input  logic [STAGES-1:0]    st_ready_go,
  input  logic [STAGES*DW-1:0] st_result,
  input  logic [DW-1:0]        rf_rdata1,
  input  logic [DW-1:0]        rf_rdata2,
  output logic                 stall,
  output logic [DW-1:0]        rs_value,
  output logic [DW-1:0]        rt_value,
  output logic [STAGES-1:0]    st_valid
);

  // Flattened view of the per-stage tags, gathered from the generate blocks.
  logic [STAGES-1:0] tag_v;
  logic [STAGES-1:0] tag_we;
  logic [STAGES-1:0] tag_ld;
  logic [AW-1:0]     tag_dest [STAGES];

  // Per-stage source-register matches and data readiness.
  logic [STAGES-1:0] m_rs;
  logic [STAGES-1:0] m_rt;
  logic [STAGES-1:0] data_ok;

  // The last stage has no successor inside the scoreboard, so its ready_go
  // is never consumed. It retires simply by being overwritten or drained.
  logic unused_last_ready_go;
  assign unused_last_ready_go = st_ready_go[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Stage gi holds load data once it is at or past LOAD_STAGE.
      localparam bit STAGE_HAS_LOAD_DATA = (gi >= LOAD_STAGE);

      logic          v_reg;
      logic          we_reg;
      logic          ld_reg;
      logic [AW-1:0] dest_reg;

      logic          src_v;
      logic          src_we;
      logic          src_ld;
      logic [AW-1:0] src_dest;

      if (gi == 0) begin : g_head
        // EXE is fed from ID. A stalled ID presents id_to_s0_valid = 0,
        // so EXE receives a bubble.
        assign src_v    = id_to_s0_valid;
        assign src_we   = id_we;
        assign src_ld   = id_is_load;
        assign src_dest = id_dest;
      end else begin : g_body
        // Later stages take over the previous tag only when it is done.
        assign src_v    = tag_v[gi-1] && st_ready_go[gi-1];
        assign src_we   = tag_we[gi-1];
        assign src_ld   = tag_ld[gi-1];
        assign src_dest = tag_dest[gi-1];
      end

      // Valid bit: reset beats flush, and flush beats any advance.
      always_ff @(posedge clk) begin
        if (reset) begin
          v_reg <= 1'b0;
        end else if (flush) begin
          v_reg <= 1'b0;
        end else if (st_allowin[gi]) begin
          v_reg <= src_v;
        end
      end

      // Payload fields only matter while v_reg is set, so they carry no reset.
      always_ff @(posedge clk) begin
        if (st_allowin[gi]) begin
          we_reg   <= src_we;
          ld_reg   <= src_ld;
          dest_reg <= src_dest;
        end
      end

      assign tag_v[gi]    = v_reg;
      assign tag_we[gi]   = we_reg;
      assign tag_ld[gi]   = ld_reg;
      assign tag_dest[gi] = dest_reg;

      // Register 0 is hard-wired, so a write to it never creates a hazard.
      assign m_rs[gi] = v_reg && we_reg && (dest_reg != '0) &&
                        (dest_reg == id_rs) && id_use_rs;
      assign m_rt[gi] = v_reg && we_reg && (dest_reg != '0) &&
                        (dest_reg == id_rt) && id_use_rt;

      // Non-load results are ready at once. Load results are ready only
      // from LOAD_STAGE onward.
      assign data_ok[gi] = !ld_reg || STAGE_HAS_LOAD_DATA;
    end
  endgenerate

  assign st_valid = tag_v;

`ifdef PIPE_FWD_EN
  logic          rs_ok;
  logic          rt_ok;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  // Youngest matching stage owns each operand. The scan runs from oldest to
  // youngest, so the last hit (lowest index) wins.
  always_comb begin
    rs_ok  = 1'b1;
    rt_ok  = 1'b1;
    rs_fwd = rf_rdata1;
    rt_fwd = rf_rdata2;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (m_rs[i]) begin
        rs_ok  = data_ok[i];
        rs_fwd = st_result[i*DW +: DW];
      end
      if (m_rt[i]) begin
        rt_ok  = data_ok[i];
        rt_fwd = st_result[i*DW +: DW];
      end
    end
  end

  // Stall only when an owning producer's data is not yet available.
  always_comb begin
    stall    = id_valid && (!rs_ok || !rt_ok);
    rs_value = rs_fwd;
    rt_value = rt_fwd;
  end
`else
  // Without forwarding, stage results and readiness are not consulted.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{st_result, data_ok};

  // Any in-flight writer of a used source register blocks ID, including WB.
  always_comb begin
    stall    = id_valid && ((|m_rs) || (|m_rt));
    rs_value = rf_rdata1;
    rt_value = rf_rdata2;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Testbench for pipe_hazard_scoreboard: directed scenarios plus randomized
// traffic checked against a behavioural model of the tag pipeline.
module tb_pipe_hazard_scoreboard;

  localparam int STAGES     = 3;
  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int LOAD_STAGE = 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic                 id_valid;
  logic [AW-1:0]        id_rs;
  logic [AW-1:0]        id_rt;
  logic                 id_use_rs;
  logic                 id_use_rt;
  logic                 id_we;
  logic [AW-1:0]        id_dest;
  logic                 id_is_load;
  logic                 id_to_s0_valid;
  logic [STAGES-1:0]    st_allowin;
  logic [STAGES-1:0]    st_ready_go;
  logic [STAGES*DW-1:0] st_result;
  logic [DW-1:0]        rf_rdata1;
  logic [DW-1:0]        rf_rdata2;
  logic                 stall;
  logic [DW-1:0]        rs_value;
  logic [DW-1:0]        rt_value;
  logic [STAGES-1:0]    st_valid;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_scoreboard #(
    .STAGES(STAGES), .AW(AW), .DW(DW), .LOAD_STAGE(LOAD_STAGE)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_we(id_we), .id_dest(id_dest), .id_is_load(id_is_load),
    .id_to_s0_valid(id_to_s0_valid), .st_allowin(st_allowin),
    .st_ready_go(st_ready_go), .st_result(st_result),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .stall(stall), .rs_value(rs_value), .rt_value(rt_value), .st_valid(st_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model: one record per in-flight instruction slot.
  bit            mv   [STAGES];
  bit            mwe  [STAGES];
  bit            mld  [STAGES];
  logic [AW-1:0] mdest[STAGES];

  // Move instructions along the pipe for one clock.
  function automatic void model_clock();
    if (reset || flush) begin
      for (int i = 0; i < STAGES; i++) mv[i] = 1'b0;
    end else begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (st_allowin[i]) begin
          if (i == 0) begin
            mv[0] = id_to_s0_valid; mwe[0] = id_we;
            mld[0] = id_is_load;    mdest[0] = id_dest;
          end else begin
            mv[i] = mv[i-1] && st_ready_go[i-1]; mwe[i] = mwe[i-1];
            mld[i] = mld[i-1];                   mdest[i] = mdest[i-1];
          end
        end
      end
    end
  endfunction

  function automatic logic [STAGES-1:0] model_valid();
    logic [STAGES-1:0] r;
    for (int i = 0; i < STAGES; i++) r[i] = mv[i];
    return r;
  endfunction

  // Expected ID-side outputs for the model state and the current inputs.
  function automatic void model_eval(output bit e_stall, output logic [DW-1:0] e_rs,
                                     output logic [DW-1:0] e_rt);
    int ors = -1;
    int ort = -1;
    for (int i = 0; i < STAGES; i++) begin
      if (ors < 0 && mv[i] && mwe[i] && mdest[i] != 0 && mdest[i] == id_rs && id_use_rs) ors = i;
      if (ort < 0 && mv[i] && mwe[i] && mdest[i] != 0 && mdest[i] == id_rt && id_use_rt) ort = i;
    end
`ifdef PIPE_FWD_EN
    e_stall = id_valid && ((ors >= 0 && mld[ors] && ors < LOAD_STAGE) ||
                           (ort >= 0 && mld[ort] && ort < LOAD_STAGE));
    e_rs = (ors >= 0) ? st_result[ors*DW +: DW] : rf_rdata1;
    e_rt = (ort >= 0) ? st_result[ort*DW +: DW] : rf_rdata2;
`else
    e_stall = id_valid && (ors >= 0 || ort >= 0);
    e_rs = rf_rdata1;
    e_rt = rf_rdata2;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_we = 0; id_dest = 0; id_is_load = 0; id_to_s0_valid = 0;
    st_allowin = '1; st_ready_go = '1; st_result = '0;
    rf_rdata1 = 32'h1111_0001; rf_rdata2 = 32'h2222_0002;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] dest, input logic ld);
    id_to_s0_valid = 1; id_we = we; id_dest = dest; id_is_load = ld;
    tick();
    id_to_s0_valid = 0; id_we = 0; id_dest = 0; id_is_load = 0;
  endtask

  task automatic clear_pipe();
    flush = 1; tick(); flush = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    tick(); tick();
    id_valid = 1; id_rs = 3; id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (st_valid !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", st_valid); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if (rs_value !== rf_rdata1 || rt_value !== rf_rdata2) begin
      failures++; $display("FAIL reset_operands got=%h/%h exp=%h/%h", rs_value, rt_value, rf_rdata1, rf_rdata2);
    end
    $display("test_reset done");
    reset = 0; idle_inputs(); tick();
  endtask

  task automatic test_reset_midstream();
    issue(1, 6, 1); issue(1, 6, 1); issue(1, 6, 1);
    id_valid = 1; id_rs = 6; id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (st_valid !== 3'b111) begin failures++; $display("FAIL mid_fill got=%b exp=111", st_valid); end
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL mid_stall_before got=%b exp=1", stall); end
    reset = 1; tick();
    @(negedge clk);
    checks++;
    if (st_valid !== 3'b000 || stall !== 1'b0) begin
      failures++; $display("FAIL mid_reset_edge1 got=%b/%b exp=000/0", st_valid, stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (st_valid !== 3'b000 || stall !== 1'b0) begin
      failures++; $display("FAIL mid_reset_edge2 got=%b/%b exp=000/0", st_valid, stall);
    end
    $display("test_reset_midstream done");
    reset = 0; idle_inputs(); tick();
  endtask

  task automatic test_flush();
    issue(1, 9, 0); issue(1, 9, 0);
    flush = 1; id_to_s0_valid = 1; id_we = 1; id_dest = 9; st_allowin = '1;
    tick();
    idle_inputs();
    id_valid = 1; id_rs = 9; id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (st_valid !== 3'b000) begin failures++; $display("FAIL flush_valid got=%b exp=000", st_valid); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    $display("test_flush done");
    idle_inputs(); tick();
  endtask

`ifdef PIPE_FWD_EN
  task automatic test_forwarding();
    clear_pipe();
    issue(1, 3, 0);
    id_valid = 1; id_rs = 3; id_use_rs = 1;
    st_result[0*DW +: DW] = 32'h11;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || rs_value !== 32'h11) begin
      failures++; $display("FAIL fwd_exe got=%b/%h exp=0/00000011", stall, rs_value);
    end
    idle_inputs(); clear_pipe();
    issue(1, 5, 1);
    id_valid = 1; id_rt = 5; id_use_rt = 1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL fwd_loaduse_exe got=%b exp=1", stall); end
    tick();
    st_result[1*DW +: DW] = 32'hCAFE;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || rt_value !== 32'hCAFE) begin
      failures++; $display("FAIL fwd_load_mem got=%b/%h exp=0/0000cafe", stall, rt_value);
    end
    idle_inputs(); clear_pipe();
    issue(1, 7, 0); issue(1, 7, 0);
    id_valid = 1; id_rs = 7; id_use_rs = 1;
    st_result[0*DW +: DW] = 32'hA; st_result[1*DW +: DW] = 32'hB;
    @(negedge clk);
    checks++;
    if (rs_value !== 32'hA) begin failures++; $display("FAIL fwd_youngest got=%h exp=0000000a", rs_value); end
    idle_inputs(); clear_pipe();
    issue(1, 0, 0);
    id_valid = 1; id_rs = 0; id_use_rs = 1; st_result[0*DW +: DW] = 32'h55;
    @(negedge clk);
    checks++;
    if (rs_value !== rf_rdata1 || stall !== 1'b0) begin
      failures++; $display("FAIL fwd_reg0 got=%h/%b exp=%h/0", rs_value, stall, rf_rdata1);
    end
    $display("test_forwarding done");
    idle_inputs(); clear_pipe();
  endtask
`else
  task automatic test_no_forward();
    clear_pipe();
    issue(1, 4, 0);
    id_valid = 1; id_rs = 4; id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL nofwd_exe got=%b exp=1", stall); end
    tick(); tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || st_valid !== 3'b100) begin
      failures++; $display("FAIL nofwd_wb got=%b/%b exp=1/100", stall, st_valid);
    end
    st_allowin = 3'b000; tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL nofwd_wb_hold got=%b exp=1", stall); end
    id_use_rs = 0; id_rt = 4; id_use_rt = 0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL nofwd_unused_rt got=%b exp=0", stall); end
    checks++;
    if (rs_value !== rf_rdata1 || rt_value !== rf_rdata2) begin
      failures++; $display("FAIL nofwd_operands got=%h/%h", rs_value, rt_value);
    end
    id_use_rs = 1; st_allowin = '1; tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || st_valid !== 3'b000) begin
      failures++; $display("FAIL nofwd_drained got=%b/%b exp=0/000", stall, st_valid);
    end
    $display("test_no_forward done");
    idle_inputs(); clear_pipe();
  endtask
`endif

  task automatic test_random();
    bit            e_stall;
    logic [DW-1:0] e_rs;
    logic [DW-1:0] e_rt;
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset       = ($urandom_range(63) == 0);
      flush       = ($urandom_range(15) == 0);
      id_valid    = $urandom_range(1);
      id_rs       = AW'($urandom_range(3));
      id_rt       = AW'($urandom_range(3));
      id_use_rs   = $urandom_range(1);
      id_use_rt   = $urandom_range(1);
      id_we       = ($urandom_range(3) != 0);
      id_dest     = AW'($urandom_range(3));
      id_is_load  = $urandom_range(1);
      st_allowin  = STAGES'($urandom_range(7) | $urandom_range(7));
      st_ready_go = STAGES'($urandom_range(7) | $urandom_range(7));
      st_result   = {$urandom, $urandom, $urandom};
      rf_rdata1   = $urandom;
      rf_rdata2   = $urandom;
      @(negedge clk);
      model_eval(e_stall, e_rs, e_rt);
      checks++;
      if (st_valid !== model_valid()) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, st_valid, model_valid());
      end
      checks++;
      if (stall !== e_stall) begin
        failures++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, stall, e_stall);
      end
      checks++;
      if (rs_value !== e_rs || rt_value !== e_rt) begin
        failures++; $display("FAIL rand_operands cyc=%0d got=%h/%h exp=%h/%h", cyc, rs_value, rt_value, e_rs, e_rt);
      end
      id_to_s0_valid = id_valid && !e_stall && ($urandom_range(3) != 0);
      tick();
    end
    $display("test_random done");
    reset = 0; idle_inputs(); tick();
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_flush();
`ifdef PIPE_FWD_EN
    test_forwarding();
`else
    test_no_forward();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
